// File: rtl/score_collector_pkg.sv
// sc_pkg: shared types and helpers for the score_collector drain stage.
//   sc_entry_t : one FIFO entry {id, unbiased signed score}
//   unbias()   : removes the score bias (result - zero, two's complement)
// The package widths set the entry layout; the top-level SCORE_WIDTH and
// ID_WIDTH parameters must keep the same values.
package sc_pkg;

    localparam int unsigned SC_SCORE_WIDTH = 12;
    localparam int unsigned SC_ID_WIDTH    = 48;

    typedef struct packed {
        logic [SC_ID_WIDTH-1:0]           id;
        logic signed [SC_SCORE_WIDTH-1:0] score;
    } sc_entry_t;

    // Truncating subtraction; with zero = 2**(W-1) this flips the MSB.
    function automatic logic signed [SC_SCORE_WIDTH-1:0] unbias(
        input logic [SC_SCORE_WIDTH-1:0] result,
        input logic [SC_SCORE_WIDTH-1:0] zero
    );
        return result - zero;
    endfunction

endpackage

// File: rtl/score_collector_if.sv
// score_collector_if: valid/ready output stream of the score collector.
//   out_valid : head entry valid        (master -> slave)
//   out_ready : consumer accepts head   (slave  -> master)
//   out_id    : ID of the head entry    (master -> slave)
//   out_score : unbiased signed score   (master -> slave)
interface score_collector_if #(
    parameter int unsigned ID_WIDTH    = 48,
    parameter int unsigned SCORE_WIDTH = 12
);
    logic                          out_valid;
    logic                          out_ready;
    logic [ID_WIDTH-1:0]           out_id;
    logic signed [SCORE_WIDTH-1:0] out_score;

    modport master (output out_valid, output out_id, output out_score, input out_ready);
    modport slave  (input out_valid, input out_id, input out_score, output out_ready);
endinterface

// File: rtl/score_collector_fifo.sv
// sc_sync_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write request and data; accepted when not full, or when full
//              and a pop happens in the same cycle
//   full     : no free entry
//   pop      : remove head (ignored when empty)
//   valid    : head present; dout is the head, forced to zero when empty
module sc_sync_fifo #(
    parameter int unsigned WIDTH = 60,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);
    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             empty, do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign valid   = !empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end
endmodule

// File: rtl/score_collector.sv
// score_collector: drain stage for ScoreBank_v2.
//   clk, rst  : clock, synchronous active-high reset
//   results   : 2*MODULES biased scores, slot j at [j*SCORE_WIDTH +: SCORE_WIDTH]
//   IDs       : 2*MODULES IDs, same packing
//   vld       : per-slot valid level
//   clear     : new query; clears max, count and overflow
//   out_if    : valid/ready stream of {id, unbiased score}
//   max_*     : running maximum for the current query
//   count     : FIFO writes since clear (saturating)
//   overflow  : sticky, a pending result on some slot was overwritten
module score_collector
    import sc_pkg::*;
#(
    parameter int unsigned SCORE_WIDTH = 12,
    parameter int unsigned ID_WIDTH    = 48,
    parameter int unsigned MODULES     = 10,
    parameter int unsigned ZERO        = 2**(SCORE_WIDTH-1),
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [0:2*MODULES*SCORE_WIDTH-1]  results,
    input  logic [0:2*MODULES*ID_WIDTH-1]     IDs,
    input  logic [0:2*MODULES-1]              vld,
    input  logic                              clear,
    score_collector_if.master                 out_if,
    output logic                              max_valid,
    output logic [ID_WIDTH-1:0]               max_id,
    output logic signed [SCORE_WIDTH-1:0]     max_score,
    output logic [15:0]                       count,
    output logic                              overflow
);
    localparam int unsigned SLOTS = 2*MODULES;

    logic [0:SLOTS-1]      vld_q, vld_d;
    logic [ID_WIDTH-1:0]   id_q [SLOTS];
    logic [ID_WIDTH-1:0]   id_d [SLOTS];
    logic [SLOTS-1:0]      pend_q, pend_d, new_res, grant;
    sc_entry_t             cap_q [SLOTS];
    sc_entry_t             cap_d [SLOTS];
    logic                  loss;

    logic                  fifo_full, fifo_valid, push;
    sc_entry_t             push_entry, head;

    logic                          max_valid_q, max_valid_d, max_valid_base;
    logic [ID_WIDTH-1:0]           max_id_q, max_id_d;
    logic signed [SCORE_WIDTH-1:0] max_score_q, max_score_d;
    logic [15:0]                   count_q, count_d, count_base;
    logic                          overflow_q, overflow_d;

    // Detection, capture and lowest-index-first arbitration.
    always_comb begin
        vld_d      = vld;
        new_res    = '0;
        grant      = '0;
        push       = 1'b0;
        push_entry = '0;
        pend_d     = pend_q;
        cap_d      = cap_q;
        loss       = 1'b0;
        for (int unsigned j = 0; j < SLOTS; j++) begin
            id_d[j]    = IDs[j*ID_WIDTH +: ID_WIDTH];
            new_res[j] = vld[j] && (!vld_q[j] || (id_d[j] != id_q[j]));
        end
        if (!fifo_full) begin
            for (int unsigned j = 0; j < SLOTS; j++) begin
                if (pend_q[j] && !push) begin
                    push       = 1'b1;
                    grant[j]   = 1'b1;
                    push_entry = cap_q[j];
                end
            end
        end
        // A slot drained this cycle may be refilled without counting as a loss.
        for (int unsigned j = 0; j < SLOTS; j++) begin
            if (new_res[j]) begin
                cap_d[j].id    = id_d[j];
                cap_d[j].score = unbias(results[j*SCORE_WIDTH +: SCORE_WIDTH],
                                        SCORE_WIDTH'(ZERO));
                if (pend_q[j] && !grant[j]) begin
                    loss = 1'b1;
                end
            end
            pend_d[j] = new_res[j] || (pend_q[j] && !grant[j]);
        end
    end

    // Max and count; clear takes effect first so a coinciding write starts the new query.
    always_comb begin
        max_valid_base = clear ? 1'b0 : max_valid_q;
        count_base     = clear ? '0 : count_q;
        max_valid_d    = max_valid_base;
        max_id_d       = max_id_q;
        max_score_d    = max_score_q;
        count_d        = count_base;
        overflow_d     = (clear ? 1'b0 : overflow_q) || loss;
        if (push) begin
            if (!max_valid_base || (push_entry.score > max_score_q)) begin
                max_id_d    = push_entry.id;
                max_score_d = push_entry.score;
            end
            max_valid_d = 1'b1;
            if (count_base != 16'hFFFF) begin
                count_d = count_base + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            id_q        <= '{default: '0};
            pend_q      <= '0;
            cap_q       <= '{default: '0};
            max_valid_q <= 1'b0;
            max_id_q    <= '0;
            max_score_q <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            id_q        <= id_d;
            pend_q      <= pend_d;
            cap_q       <= cap_d;
            max_valid_q <= max_valid_d;
            max_id_q    <= max_id_d;
            max_score_q <= max_score_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    sc_sync_fifo #(
        .WIDTH ($bits(sc_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .full  (fifo_full),
        .pop   (out_if.out_ready),
        .dout  (head),
        .valid (fifo_valid)
    );

    assign out_if.out_valid = fifo_valid;
    assign out_if.out_id    = head.id;
    assign out_if.out_score = head.score;
    assign max_valid        = max_valid_q;
    assign max_id           = max_id_q;
    assign max_score        = max_score_q;
    assign count            = count_q;
    assign overflow         = overflow_q;
endmodule

// File: tb/tb_score_collector.sv
module tb_score_collector;
    localparam int SW = 12;
    localparam int IW = 48;
    localparam int M  = 10;
    localparam int S  = 2*M;
    localparam int FD = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic [0:S*SW-1]   results = '0;
    logic [0:S*IW-1]   ids = '0;
    logic [0:S-1]      vld = '0;
    logic              max_valid, overflow;
    logic [IW-1:0]     max_id;
    logic signed [SW-1:0] max_score;
    logic [15:0]       count;

    score_collector_if #(.ID_WIDTH(IW), .SCORE_WIDTH(SW)) oif ();

    score_collector #(
        .SCORE_WIDTH (SW),
        .ID_WIDTH    (IW),
        .MODULES     (M),
        .ZERO        (2048),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .results   (results),
        .IDs       (ids),
        .vld       (vld),
        .clear     (clear),
        .out_if    (oif),
        .max_valid (max_valid),
        .max_id    (max_id),
        .max_score (max_score),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: slots hold at most one undelivered result each,
    // the output stream is a bounded queue.
    typedef struct { logic [IW-1:0] id; logic [SW-1:0] sc; } ent_t;
    ent_t          mq[$];
    bit            m_pend[S];
    ent_t          m_cap[S];
    bit            m_pv[S];
    logic [IW-1:0] m_pid[S];
    bit            m_mv;
    logic [IW-1:0] m_mid;
    logic [SW-1:0] m_ms;
    int            m_cnt;
    bit            m_ovf;
    logic [IW-1:0] dlv[$];

    always @(posedge clk) begin : model
        bit            full;
        int            g;
        ent_t          e;
        logic [IW-1:0] cid;
        if (rst) begin
            mq.delete();
            for (int j = 0; j < S; j++) begin
                m_pend[j] = 0; m_pv[j] = 0; m_pid[j] = '0;
                m_cap[j].id = '0; m_cap[j].sc = '0;
            end
            m_mv = 0; m_mid = '0; m_ms = '0; m_cnt = 0; m_ovf = 0;
        end else begin
            if (oif.out_valid && oif.out_ready) dlv.push_back(oif.out_id);
            full = (mq.size() == FD);
            if (mq.size() > 0 && oif.out_ready) void'(mq.pop_front());
            g = -1;
            if (!full) begin
                for (int j = 0; j < S; j++) begin
                    if (m_pend[j]) begin g = j; break; end
                end
            end
            if (clear) begin m_mv = 0; m_cnt = 0; m_ovf = 0; end
            if (g >= 0) begin
                e = m_cap[g];
                m_pend[g] = 0;
                mq.push_back(e);
                if (!m_mv || $signed(e.sc) > $signed(m_ms)) begin
                    m_mid = e.id; m_ms = e.sc;
                end
                m_mv = 1;
                if (m_cnt < 65535) m_cnt++;
            end
            for (int j = 0; j < S; j++) begin
                cid = ids[j*IW +: IW];
                if (vld[j] && (!m_pv[j] || cid != m_pid[j])) begin
                    if (m_pend[j]) m_ovf = 1;
                    m_pend[j] = 1;
                    m_cap[j].id = cid;
                    m_cap[j].sc = results[j*SW +: SW] - 12'd2048;
                end
                m_pv[j]  = vld[j];
                m_pid[j] = cid;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("out_valid", 64'(oif.out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_id", 64'(oif.out_id), 64'(mq[0].id));
            chk("out_score", {52'b0, oif.out_score}, 64'(mq[0].sc));
        end
        chk("max_valid", 64'(max_valid), 64'(m_mv));
        chk("max_id", 64'(max_id), 64'(m_mid));
        chk("max_score", {52'b0, max_score}, 64'(m_ms));
        chk("count", 64'(count), 64'(m_cnt));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic slot(input int j, input logic [IW-1:0] id, input logic [SW-1:0] r);
        ids[j*IW +: IW]     = id;
        results[j*SW +: SW] = r;
        vld[j]              = 1'b1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; cyc(1); clear = 1'b0;
    endtask

    int exp_ids[$];

    task automatic chk_dlv(input string nm);
        chk({nm, "_n"}, 64'(dlv.size()), 64'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size() && i < dlv.size(); i++)
            chk(nm, 64'(dlv[i]), 64'(exp_ids[i]));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_out_valid"}, 64'(oif.out_valid), 64'd0);
        chk({nm, "_out_id"}, 64'(oif.out_id), 64'd0);
        chk({nm, "_out_score"}, {52'b0, oif.out_score}, 64'd0);
        chk({nm, "_max_valid"}, 64'(max_valid), 64'd0);
        chk({nm, "_max_id"}, 64'(max_id), 64'd0);
        chk({nm, "_max_score"}, {52'b0, max_score}, 64'd0);
        chk({nm, "_count"}, 64'(count), 64'd0);
        chk({nm, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        oif.out_ready = 1'b1;
        cyc(3);
        chk_zero("reset");
        rst = 1'b0;

        // Single result, held valid for 50 cycles.
        dlv.delete();
        slot(3, 48'd7, 12'h80A);
        cyc(1);
        chk("t1_lat1", 64'(oif.out_valid), 64'd0);
        cyc(1);
        chk("t1_valid", 64'(oif.out_valid), 64'd1);
        chk("t1_id", 64'(oif.out_id), 64'd7);
        chk("t1_score", {52'b0, oif.out_score}, 64'h00A);
        cyc(50);
        exp_ids = '{7};
        chk_dlv("t1_dlv");
        chk("t1_count", 64'(count), 64'd1);
        vld = '0; cyc(2); pulse_clear();

        // Simultaneous results drain in slot order.
        dlv.delete();
        slot(0, 48'd1, 12'h801); slot(5, 48'd2, 12'h802); slot(19, 48'd3, 12'h803);
        cyc(8);
        exp_ids = '{1, 2, 3};
        chk_dlv("t2_dlv");
        chk("t2_count", 64'(count), 64'd3);
        vld = '0; cyc(2); pulse_clear();

        // Backpressure: 8 stored, 9th pending, none lost.
        oif.out_ready = 1'b0;
        dlv.delete();
        for (int j = 0; j < 9; j++) slot(j, 48'(100 + j), 12'(12'h800 + j));
        cyc(14);
        chk("t3_held", 64'(dlv.size()), 64'd0);
        chk("t3_valid", 64'(oif.out_valid), 64'd1);
        oif.out_ready = 1'b1;
        cyc(14);
        exp_ids = '{100, 101, 102, 103, 104, 105, 106, 107, 108};
        chk_dlv("t3_dlv");
        chk("t3_overflow", 64'(overflow), 64'd0);
        chk("t3_count", 64'(count), 64'd9);
        vld = '0; cyc(2); pulse_clear();

        // Overflow: pending ID 10 overwritten by ID 11 while FIFO is full.
        oif.out_ready = 1'b0;
        dlv.delete();
        for (int j = 0; j < 8; j++) slot(j, 48'(200 + j), 12'h800);
        cyc(12);
        slot(2, 48'd10, 12'h810);
        cyc(3);
        chk("t4_no_ovf_yet", 64'(overflow), 64'd0);
        slot(2, 48'd11, 12'h811);
        cyc(2);
        chk("t4_overflow", 64'(overflow), 64'd1);
        oif.out_ready = 1'b1;
        cyc(15);
        exp_ids = '{200, 201, 202, 203, 204, 205, 206, 207, 11};
        chk_dlv("t4_dlv");
        vld = '0; cyc(2); pulse_clear();

        // Max with a tie, then clear coinciding with a write of -3.
        slot(0, 48'd4, 12'h805); slot(1, 48'd5, 12'h814); slot(2, 48'd6, 12'h814);
        cyc(6);
        chk("t5_max_valid", 64'(max_valid), 64'd1);
        chk("t5_max_id", 64'(max_id), 64'd5);
        chk("t5_max_score", {52'b0, max_score}, 64'h014);
        slot(4, 48'd9, 12'h7FD);
        cyc(1);
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("t5_clr_max_score", {52'b0, max_score}, 64'hFFD);
        chk("t5_clr_max_id", 64'(max_id), 64'd9);
        chk("t5_clr_count", 64'(count), 64'd1);
        vld = '0; cyc(4);

        // Reset with 4 queued and 3 pending; held slots re-reported once.
        oif.out_ready = 1'b0;
        for (int j = 0; j < 4; j++) slot(j, 48'(300 + j), 12'h820);
        cyc(7);
        for (int j = 4; j < 7; j++) slot(j, 48'(300 + j), 12'h830);
        cyc(1);
        rst = 1'b1; cyc(1);
        chk_zero("t6_rst");
        rst = 1'b0;
        oif.out_ready = 1'b1;
        dlv.delete();
        cyc(16);
        exp_ids = '{300, 301, 302, 303, 304, 305, 306};
        chk_dlv("t6_dlv");
        vld = '0; cyc(2);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            oif.out_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 60) == 0);
            rst = ($urandom_range(0, 400) == 0);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                int j;
                j = int'($urandom_range(0, S - 1));
                if ($urandom_range(0, 1) == 0) vld[j] = ~vld[j];
                else begin
                    ids[j*IW +: IW]     = 48'($urandom_range(0, 7));
                    results[j*SW +: SW] = 12'($urandom_range(0, 4095));
                end
            end
            cyc(1);
        end
        rst = 1'b0; clear = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
